// File: rtl/fft_out_streamer.sv
// fft_out_streamer: reads a DEPTH-word complex frame from a 1-cycle-latency register file
// and streams it as real/imag beats over valid/ready with index, last and done.
module fft_out_streamer #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 32,
    parameter int BIT_REVERSE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic                    ram_re,
    input  logic [2*DATA_WIDTH-1:0] ram_data,
    output logic [DATA_WIDTH-1:0]   m_data_r,
    output logic [DATA_WIDTH-1:0]   m_data_i,
    output logic [ADDR_WIDTH-1:0]   m_index,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state_q;
    logic [ADDR_WIDTH-1:0] seq_q, seq_rev, raddr_q, beat_q;
    logic [1:0] count_q, count_d, rd_q, wr_q;
    logic inflight_q, done_q, pop;
    logic [2*DATA_WIDTH-1:0] data_q [3];
    logic [ADDR_WIDTH-1:0] idx_q [3];
    logic [2*DATA_WIDTH-1:0] head;

    for (genvar g = 0; g < ADDR_WIDTH; g++) begin : g_rev
        assign seq_rev[g] = seq_q[ADDR_WIDTH-1-g];
    end

    always_comb begin
        busy = state_q != IDLE;
        done = done_q;
        ram_addr = BIT_REVERSE != 0 ? seq_rev : seq_q;
        // FIFO occupancy plus the read in flight never exceeds the 3 FIFO slots
        ram_re = state_q == RUN && (count_q + {1'b0, inflight_q}) < 2'd3;
        m_valid = count_q != 2'd0;
        head = m_valid ? data_q[rd_q] : '0;
        m_data_r = head[2*DATA_WIDTH-1:DATA_WIDTH];
        m_data_i = head[DATA_WIDTH-1:0];
        m_index = m_valid ? idx_q[rd_q] : '0;
        m_last = m_valid && beat_q == ADDR_WIDTH'(DEPTH-1);
        pop = m_valid && m_ready;
        count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            seq_q <= '0;
            raddr_q <= '0;
            beat_q <= '0;
            count_q <= '0;
            rd_q <= '0;
            wr_q <= '0;
            inflight_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            inflight_q <= ram_re;
            done_q <= 1'b0;
            count_q <= count_d;
            if (ram_re) raddr_q <= ram_addr;
            if (inflight_q) wr_q <= wr_q == 2'd2 ? 2'd0 : wr_q + 2'd1;
            if (pop) begin
                rd_q <= rd_q == 2'd2 ? 2'd0 : rd_q + 2'd1;
                beat_q <= beat_q + ADDR_WIDTH'(1);
            end
            // done_q blocks a start that coincides with the completion pulse
            if (state_q == IDLE && start && !done_q) begin
                state_q <= RUN;
                seq_q <= '0;
                beat_q <= '0;
            end else if (state_q == RUN && ram_re) begin
                if (seq_q == ADDR_WIDTH'(DEPTH-1)) state_q <= FLUSH;
                else seq_q <= seq_q + ADDR_WIDTH'(1);
            end else if (state_q == FLUSH && pop && m_last) begin
                state_q <= IDLE;
                done_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (inflight_q) begin
            data_q[wr_q] <= ram_data;
            idx_q[wr_q] <= raddr_q;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(inflight_q && !pop && count_q == 2'd3) && !(pop && count_q == 2'd0));
endmodule
